// File: rtl/iaram_stream_loader_if.sv
// Interface bundling the IARAM loader's write streams, PE read port and status outputs.
// master = upstream stream/PE side, slave = the loader itself.
interface iaram_stream_loader_if #(
   parameter int LANES  = 4,
   parameter int DATA_W = 16,
   parameter int IDX_W  = 4,
   parameter int NUM_CH = 3,
   parameter int DEPTH  = 64
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [LANES-1:0]          in_valid;
   logic [LANES*DATA_W-1:0]   in_data;
   logic                      in_dense;
   logic [CW-1:0]             in_channel;
   logic [LANES-1:0]          idx_valid;
   logic [LANES*IDX_W-1:0]    idx_data;
   logic [CW-1:0]             idx_channel;
   logic                      stream_finish;
   logic                      layer_clear;
   logic                      rd_en;
   logic [CW-1:0]             rd_channel;
   logic [AW-1:0]             rd_addr;
   logic [DATA_W-1:0]         rd_data;
   logic [IDX_W-1:0]          rd_idx;
   logic                      rd_valid;
   logic [NUM_CH*(AW+1)-1:0]  ch_count;
   logic [NUM_CH-1:0]         ch_dense;
   logic                      loaded;
   logic                      overflow;
   logic                      mismatch;

   modport master (
      output in_valid, in_data, in_dense, in_channel,
      output idx_valid, idx_data, idx_channel,
      output stream_finish, layer_clear,
      output rd_en, rd_channel, rd_addr,
      input  rd_data, rd_idx, rd_valid,
      input  ch_count, ch_dense, loaded, overflow, mismatch
   );

   modport slave (
      input  in_valid, in_data, in_dense, in_channel,
      input  idx_valid, idx_data, idx_channel,
      input  stream_finish, layer_clear,
      input  rd_en, rd_channel, rd_addr,
      output rd_data, rd_idx, rd_valid,
      output ch_count, ch_dense, loaded, overflow, mismatch
   );
endinterface

// File: rtl/iaram_stream_loader.sv
// Packs multi-lane activation/index beats into per-channel IARAM + index RAM, with a 1-cycle PE read port.
// Optional macro IARAM_ZERO_SKIP_EN: compress dense beats on the fly (drop zeros, synthesize indices).
module iaram_stream_loader #(
   parameter int LANES  = 4,
   parameter int DATA_W = 16,
   parameter int IDX_W  = 4,
   parameter int NUM_CH = 3,
   parameter int DEPTH  = 64
) (
   input logic                  clk,
   input logic                  rst,
   iaram_stream_loader_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int PW = AW + 2;
`ifdef IARAM_ZERO_SKIP_EN
   localparam int IWP = 2 * LANES;
`else
   localparam int IWP = LANES;
`endif

   typedef logic [PW-1:0] ext_t;
   localparam ext_t         DEPTH_X = ext_t'(DEPTH);
   localparam logic [AW:0]  DEPTH_P = (AW+1)'(DEPTH);
   localparam logic [CW:0]  CH_LIM  = (CW+1)'(NUM_CH);

   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

   state_t              state_q, state_d;
   logic [AW:0]         dptr_q [NUM_CH];
   logic [AW:0]         dptr_d [NUM_CH];
   logic [AW:0]         iptr_q [NUM_CH];
   logic [AW:0]         iptr_d [NUM_CH];
   logic [NUM_CH-1:0]   ch_dense_q, ch_dense_d;
   logic                loaded_q, loaded_d;
   logic                overflow_q, overflow_d;
   logic                mismatch_q, mismatch_d;
   logic                rd_valid_q, rd_valid_d;
   logic [DATA_W-1:0]   rd_data_q, rd_data_d;
   logic [IDX_W-1:0]    rd_idx_q, rd_idx_d;
`ifdef IARAM_ZERO_SKIP_EN
   logic [AW:0]         pos_q [NUM_CH];
   logic [AW:0]         pos_d [NUM_CH];
`endif

   logic [DATA_W-1:0]   data_mem [NUM_CH][DEPTH];
   logic [IDX_W-1:0]    idx_mem  [NUM_CH][DEPTH];

   logic [LANES-1:0]    dwr_en;
   logic [AW-1:0]       dwr_addr [LANES];
   logic [IWP-1:0]      iwr_en;
   logic [AW-1:0]       iwr_addr [IWP];
   logic [IDX_W-1:0]    iwr_val  [IWP];
   logic [CW-1:0]       iwr_ch   [IWP];

   logic                accept, d_ok, i_ok;
   logic [LANES-1:0]    d_valid;
   ext_t                base, addr, k;

   always_comb begin
      state_d     = state_q;
      dptr_d      = dptr_q;
      iptr_d      = iptr_q;
      ch_dense_d  = ch_dense_q;
      loaded_d    = loaded_q;
      overflow_d  = overflow_q;
      mismatch_d  = mismatch_q;
      rd_valid_d  = bus.rd_en;
      rd_data_d   = rd_data_q;
      rd_idx_d    = rd_idx_q;
`ifdef IARAM_ZERO_SKIP_EN
      pos_d       = pos_q;
`endif
      dwr_en      = '0;
      iwr_en      = '0;
      for (int i = 0; i < LANES; i++) dwr_addr[i] = '0;
      for (int i = 0; i < IWP; i++) begin
         iwr_addr[i] = '0;
         iwr_val[i]  = '0;
         iwr_ch[i]   = '0;
      end
      base    = '0;
      addr    = '0;
      k       = '0;
      accept  = !bus.layer_clear && (state_q != DONE);
      d_ok    = {1'b0, bus.in_channel}  < CH_LIM;
      i_ok    = {1'b0, bus.idx_channel} < CH_LIM;
      d_valid = bus.in_valid;
`ifdef IARAM_ZERO_SKIP_EN
      if (bus.in_dense) begin
         for (int i = 0; i < LANES; i++)
            if (bus.in_data[i*DATA_W +: DATA_W] == '0) d_valid[i] = 1'b0;
      end
`endif

      // Data beat: k-th valid lane lands at wptr+k; lanes past DEPTH are dropped.
      if (accept && d_ok) begin
         base = {1'b0, dptr_q[bus.in_channel]};
         for (int i = 0; i < LANES; i++) begin
            if (d_valid[i]) begin
               addr = base + k;
               if (addr < DEPTH_X) begin
                  dwr_en[i]   = 1'b1;
                  dwr_addr[i] = addr[AW-1:0];
               end else begin
                  overflow_d  = 1'b1;
               end
               k = k + ext_t'(1);
            end
         end
         addr = base + k;
         dptr_d[bus.in_channel] = (addr > DEPTH_X) ? DEPTH_P : addr[AW:0];
`ifdef IARAM_ZERO_SKIP_EN
         if (bus.in_dense) begin
            k = '0;
            for (int i = 0; i < LANES; i++) begin
               if (dwr_en[i]) begin
                  iwr_en[LANES+i]   = 1'b1;
                  iwr_addr[LANES+i] = dwr_addr[i];
                  iwr_ch[LANES+i]   = bus.in_channel;
                  iwr_val[LANES+i]  = pos_q[bus.in_channel][IDX_W-1:0] + k[IDX_W-1:0];
               end
               if (bus.in_valid[i]) k = k + ext_t'(1);
            end
            pos_d[bus.in_channel] = pos_q[bus.in_channel] + k[AW:0];
         end
`else
         if (bus.in_dense && (|bus.in_valid)) ch_dense_d[bus.in_channel] = 1'b1;
`endif
      end

      if (accept && i_ok) begin
         base = {1'b0, iptr_q[bus.idx_channel]};
         k    = '0;
         for (int i = 0; i < LANES; i++) begin
            if (bus.idx_valid[i]) begin
               addr = base + k;
               if (addr < DEPTH_X) begin
                  iwr_en[i]   = 1'b1;
                  iwr_addr[i] = addr[AW-1:0];
                  iwr_val[i]  = bus.idx_data[i*IDX_W +: IDX_W];
                  iwr_ch[i]   = bus.idx_channel;
               end else begin
                  overflow_d  = 1'b1;
               end
               k = k + ext_t'(1);
            end
         end
         addr = base + k;
         iptr_d[bus.idx_channel] = (addr > DEPTH_X) ? DEPTH_P : addr[AW:0];
      end
`ifdef IARAM_ZERO_SKIP_EN
      if (accept && d_ok && bus.in_dense) iptr_d[bus.in_channel] = dptr_d[bus.in_channel];
`endif

      // Mismatch is judged on post-write pointers so a beat alongside finish counts.
      if (bus.layer_clear) begin
         state_d    = IDLE;
         ch_dense_d = '0;
         loaded_d   = 1'b0;
         overflow_d = 1'b0;
         mismatch_d = 1'b0;
         for (int c = 0; c < NUM_CH; c++) begin
            dptr_d[c] = '0;
            iptr_d[c] = '0;
`ifdef IARAM_ZERO_SKIP_EN
            pos_d[c]  = '0;
`endif
         end
      end else if (state_q != DONE) begin
         if (bus.stream_finish) begin
            state_d  = DONE;
            loaded_d = 1'b1;
            for (int c = 0; c < NUM_CH; c++)
               if (!ch_dense_d[c] && (dptr_d[c] != iptr_d[c])) mismatch_d = 1'b1;
         end else if ((state_q == IDLE) && ((|bus.in_valid) || (|bus.idx_valid))) begin
            state_d = LOAD;
         end
      end

      if (bus.rd_en) begin
         rd_data_d = '0;
         rd_idx_d  = '0;
         if ({1'b0, bus.rd_channel} < CH_LIM) begin
            rd_data_d = data_mem[bus.rd_channel][bus.rd_addr];
            if (!ch_dense_q[bus.rd_channel]) rd_idx_d = idx_mem[bus.rd_channel][bus.rd_addr];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         ch_dense_q <= '0;
         loaded_q   <= 1'b0;
         overflow_q <= 1'b0;
         mismatch_q <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         rd_idx_q   <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            dptr_q[c] <= '0;
            iptr_q[c] <= '0;
`ifdef IARAM_ZERO_SKIP_EN
            pos_q[c]  <= '0;
`endif
         end
      end else begin
         state_q    <= state_d;
         ch_dense_q <= ch_dense_d;
         loaded_q   <= loaded_d;
         overflow_q <= overflow_d;
         mismatch_q <= mismatch_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
         rd_idx_q   <= rd_idx_d;
         dptr_q     <= dptr_d;
         iptr_q     <= iptr_d;
`ifdef IARAM_ZERO_SKIP_EN
         pos_q      <= pos_d;
`endif
      end
   end

   // RAM arrays hold no reset; reads above see the pre-write contents.
   always_ff @(posedge clk) begin
      for (int i = 0; i < LANES; i++)
         if (dwr_en[i]) data_mem[bus.in_channel][dwr_addr[i]] <= bus.in_data[i*DATA_W +: DATA_W];
      for (int i = 0; i < IWP; i++)
         if (iwr_en[i]) idx_mem[iwr_ch[i]][iwr_addr[i]] <= iwr_val[i];
   end

   always_comb begin
      for (int c = 0; c < NUM_CH; c++) bus.ch_count[c*(AW+1) +: (AW+1)] = dptr_q[c];
   end

   assign bus.ch_dense = ch_dense_q;
   assign bus.loaded   = loaded_q;
   assign bus.overflow = overflow_q;
   assign bus.mismatch = mismatch_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.rd_data  = rd_data_q;
   assign bus.rd_idx   = rd_idx_q;
endmodule
